// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the MEM-stage load/store interface. It accepts one
//   request at a time, inserts LATENCY wait states, then performs an RV32I
//   byte/half/word access and holds a registered response until the
//   requester takes it.
//
//   Parameters
//     DEPTH    number of 32-bit words in the array (power of two)
//     LATENCY  wait states between acceptance and response (0..15)
//
//   Ports
//     clk        clock, rising edge
//     clr        asynchronous active-high reset
//     req_valid  request present
//     req_ready  responder can accept a request (IDLE only)
//     req_we     1 = store, 0 = load
//     req_addr   byte address
//     req_wdata  store data, low bytes used for SB/SH
//     req_func3  RV32I load/store func3
//     rsp_valid  response present
//     rsp_ready  requester takes the response this cycle
//     rsp_rdata  extended load result, 0 for stores and errors
//     rsp_err    misaligned, out of range or illegal func3
//
//   state | meaning
//   IDLE  | ready for a request; req_ready=1
//   WAIT  | counting wait states down to zero
//   RESP  | response registered and held until rsp_ready
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 0
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);
   localparam logic [3:0]  LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam bit          LAT0    = (LATENCY == 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  func3_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic [31:0] mem_q [DEPTH];

   // With zero latency the access happens on the accepting edge, so the
   // decode must look at the live request rather than the captured copy.
   logic        use_live;
   logic        a_we;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [2:0]  a_func3;
   logic        access_now;

   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic          legal;
   logic          misalign;
   logic          oor;
   logic          err_d;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   load_d;
   logic [31:0]   rdata_d;
   logic [3:0]    be_d;
   logic [31:0]   wdat_d;
   logic          mem_we;

   assign use_live = (state_q == IDLE);
   assign a_we     = use_live ? req_we    : we_q;
   assign a_addr   = use_live ? req_addr  : addr_q;
   assign a_wdata  = use_live ? req_wdata : wdata_q;
   assign a_func3  = use_live ? req_func3 : func3_q;

   assign access_now = (LAT0 && (state_q == IDLE) && req_valid && req_ready_q) ||
                       ((state_q == WAIT) && (cnt_q == 4'd0));

   assign word_idx = a_addr[AW+1:2];
   assign lane     = a_addr[1:0];
   assign oor      = (a_addr[31:2] >= DEPTH_W);
   assign misalign = ((a_func3[1:0] == 2'b01) && lane[0]) ||
                     ((a_func3[1:0] == 2'b10) && (lane != 2'b00));

   always_comb begin
      legal = 1'b0;
      case (a_func3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !a_we;
         default:                legal = 1'b0;
      endcase
   end

   assign err_d   = !legal || misalign || oor;
   assign rd_word = mem_q[word_idx];
   assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      rd_byte = rd_word[7:0];
      case (lane)
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         2'd3: rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
   end

   always_comb begin
      load_d = 32'd0;
      case (a_func3)
         3'b000: load_d = {{24{rd_byte[7]}}, rd_byte};
         3'b001: load_d = {{16{rd_half[15]}}, rd_half};
         3'b010: load_d = rd_word;
         3'b100: load_d = {24'd0, rd_byte};
         3'b101: load_d = {16'd0, rd_half};
         default: load_d = 32'd0;
      endcase
   end

   assign rdata_d = (err_d || a_we) ? 32'd0 : load_d;

   // Store data is replicated across lanes; the byte enables pick the lanes.
   always_comb begin
      be_d   = 4'b0000;
      wdat_d = a_wdata;
      case (a_func3)
         3'b000: begin
            be_d   = 4'b0001 << lane;
            wdat_d = {4{a_wdata[7:0]}};
         end
         3'b001: begin
            be_d   = lane[1] ? 4'b1100 : 4'b0011;
            wdat_d = {2{a_wdata[15:0]}};
         end
         3'b010: begin
            be_d   = 4'b1111;
            wdat_d = a_wdata;
         end
         default: begin
            be_d   = 4'b0000;
            wdat_d = a_wdata;
         end
      endcase
   end

   assign mem_we = access_now && a_we && !err_d && !clr;

   // Array contents survive reset, so this block has no reset branch.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be_d[i]) begin
               mem_q[word_idx][8*i +: 8] <= wdat_d[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         func3_q     <= 3'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  we_q        <= req_we;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  func3_q     <= req_func3;
                  req_ready_q <= 1'b0;
                  if (LAT0) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rdata_d;
                     rsp_err_q   <= err_d;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= LAT_M1;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rdata_d;
                  rsp_err_q   <= err_d;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= 32'd0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_rdata_q <= 32'd0;
               rsp_err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        clr       [2];
   logic        req_valid [2];
   logic        req_we    [2];
   logic        rsp_ready [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [2:0]  req_func3 [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic        rsp_err   [2];
   logic [31:0] rsp_rdata [2];

   // Byte-addressed reference image of each instance's memory.
   logic [7:0] mb [2][DEPTH*4];

   int npass = 0;
   int nchk  = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
      .clk(clk), .clr(clr[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_func3(req_func3[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
      .clk(clk), .clr(clr[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_func3(req_func3[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   function automatic int lat(input int s);
      return (s == 1) ? 3 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Reference behaviour: access size from func3, legality, alignment and
   // range rules, then a byte-wise read or write of the image.
   function automatic void model(input int s, input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [2:0] f3,
                                 output logic [31:0] rd, output logic e);
      int size;
      logic legal;
      logic [31:0] v;
      size  = 1 << f3[1:0];
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e     = !legal || ((a % size) != 0) || ((a >> 2) >= DEPTH);
      rd    = 32'd0;
      if (e) return;
      if (we) begin
         for (int i = 0; i < size; i++) mb[s][a + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = mb[s][a + i];
         if (!f3[2] && size < 4 && v[8*size-1])
            for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
         rd = v;
      end
   endfunction

   task automatic xact(input int s, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input int hold,
                       output logic [31:0] rd, output logic e);
      int n;
      logic [31:0] exp_rd;
      logic exp_e;
      model(s, we, a, wd, f3, exp_rd, exp_e);
      req_we[s] = we; req_addr[s] = a; req_wdata[s] = wd; req_func3[s] = f3;
      req_valid[s] = 1'b1;
      n = 0;
      while (!req_ready[s] && n < 50) begin @(posedge clk); #1; n++; end
      chk("accept_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1;
      // Scramble the request bus; it must be ignored until IDLE.
      req_valid[s] = 1'($urandom_range(0, 1));
      req_we[s] = 1'($urandom_range(0, 1)); req_addr[s] = $urandom;
      req_wdata[s] = $urandom; req_func3[s] = 3'($urandom_range(0, 7));
      chk("ready_low_after_accept", 32'(req_ready[s]), 32'd0);
      n = 1;
      while (!rsp_valid[s] && n < 50) begin @(posedge clk); #1; n++; end
      chk("rsp_latency", 32'(n), 32'(lat(s) + 1));
      rd = rsp_rdata[s];
      e  = rsp_err[s];
      chk("rsp_rdata", rd, exp_rd);
      chk("rsp_err", 32'(e), 32'(exp_e));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
         chk("hold_rdata", rsp_rdata[s], rd);
         chk("hold_ready_low", 32'(req_ready[s]), 32'd0);
      end
      req_valid[s] = 1'b0;
      rsp_ready[s] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[s] = 1'b0;
      chk("valid_drop", 32'(rsp_valid[s]), 32'd0);
      chk("ready_back", 32'(req_ready[s]), 32'd1);
   endtask

   task automatic rand_req(input int s);
      req_we[s]    = 1'($urandom_range(0, 1));
      req_func3[s] = 3'($urandom_range(0, 7));
      req_wdata[s] = $urandom;
      if ($urandom_range(0, 9) == 0) req_addr[s] = 32'(4*DEPTH + $urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 0) req_addr[s] = 32'($urandom_range(0, DEPTH-1) * 4);
      else req_addr[s] = 32'($urandom_range(0, 4*DEPTH-1));
   endtask

   task automatic b2b(input int s, input int nreq);
      int k, cyc, acc_prev;
      logic acc;
      logic [31:0] erd;
      logic ee;
      logic [31:0] q_rd [$];
      logic q_e [$];
      k = 0; cyc = 0; acc_prev = -1;
      rsp_ready[s] = 1'b1;
      rand_req(s);
      req_valid[s] = 1'b1;
      while ((k < nreq || q_rd.size() > 0) && cyc < 2000) begin
         acc = req_valid[s] && req_ready[s];
         if (rsp_valid[s]) begin
            if (q_rd.size() > 0) begin
               chk("b2b_rdata", rsp_rdata[s], q_rd.pop_front());
               chk("b2b_err", 32'(rsp_err[s]), 32'(q_e.pop_front()));
            end else begin
               chk("b2b_extra_rsp", 32'd1, 32'd0);
            end
         end
         if (acc) begin
            model(s, req_we[s], req_addr[s], req_wdata[s], req_func3[s], erd, ee);
            q_rd.push_back(erd);
            q_e.push_back(ee);
            if (acc_prev >= 0) chk("b2b_interval", 32'(cyc - acc_prev), 32'(lat(s) + 2));
            acc_prev = cyc;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            k++;
            if (k < nreq) rand_req(s);
            else req_valid[s] = 1'b0;
         end
      end
      chk("b2b_all_done", ((k == nreq) && (q_rd.size() == 0)) ? 32'd1 : 32'd0, 32'd1);
      rsp_ready[s] = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic e;
      int seen;
      for (int s = 0; s < 2; s++) begin
         clr[s] = 1'b1; req_valid[s] = 1'b0; req_we[s] = 1'b0; rsp_ready[s] = 1'b0;
         req_addr[s] = 32'd0; req_wdata[s] = 32'd0; req_func3[s] = 3'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
         chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata[s], 32'd0);
         chk("rst_rsp_err", 32'(rsp_err[s]), 32'd0);
         clr[s] = 1'b0;
      end
      @(posedge clk); #1;

      // Give both arrays known contents.
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < DEPTH; w++) xact(s, 1'b1, 32'(w*4), 32'd0, 3'd2, 0, rd, e);

      // Word store / load, zero latency.
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, rd, e);
      chk("sw_err", 32'(e), 32'd0);
      xact(0, 1'b0, 32'h10, 32'd0, 3'd2, 0, rd, e);
      chk("lw_0x10", rd, 32'hDEADBEEF);

      // Extension and lane writes.
      xact(0, 1'b1, 32'h20, 32'h80FF7F01, 3'd2, 0, rd, e);
      xact(0, 1'b0, 32'h21, 32'd0, 3'd0, 0, rd, e);
      chk("lb_0x21", rd, 32'h0000007F);
      xact(0, 1'b0, 32'h23, 32'd0, 3'd4, 0, rd, e);
      chk("lbu_0x23", rd, 32'h00000080);
      xact(0, 1'b0, 32'h22, 32'd0, 3'd1, 0, rd, e);
      chk("lh_0x22", rd, 32'hFFFF80FF);
      xact(0, 1'b0, 32'h22, 32'd0, 3'd5, 0, rd, e);
      chk("lhu_0x22", rd, 32'h000080FF);
      xact(0, 1'b1, 32'h22, 32'hAAAAAA55, 3'd0, 0, rd, e);
      xact(0, 1'b0, 32'h20, 32'd0, 3'd2, 0, rd, e);
      chk("lw_after_sb", rd, 32'h80557F01);

      // Error cases; none may disturb the array.
      xact(0, 1'b0, 32'h13, 32'd0, 3'd2, 0, rd, e);
      chk("lw_misalign_err", 32'(e), 32'd1);
      chk("lw_misalign_rd", rd, 32'd0);
      xact(0, 1'b1, 32'h21, 32'hFFFFFFFF, 3'd1, 0, rd, e);
      chk("sh_misalign_err", 32'(e), 32'd1);
      xact(0, 1'b0, 32'(4*DEPTH), 32'd0, 3'd2, 0, rd, e);
      chk("lw_oor_err", 32'(e), 32'd1);
      chk("lw_oor_rd", rd, 32'd0);
      xact(0, 1'b0, 32'h20, 32'd0, 3'd3, 0, rd, e);
      chk("ld_f3_011_err", 32'(e), 32'd1);
      chk("ld_f3_011_rd", rd, 32'd0);
      xact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 3'd4, 0, rd, e);
      chk("st_f3_100_err", 32'(e), 32'd1);
      xact(0, 1'b0, 32'h20, 32'd0, 3'd2, 0, rd, e);
      chk("lw_unchanged", rd, 32'h80557F01);

      // LATENCY=3 with backpressure.
      xact(1, 1'b1, 32'h80, 32'hCAFEF00D, 3'd2, 0, rd, e);
      xact(1, 1'b0, 32'h80, 32'd0, 3'd2, 5, rd, e);
      chk("lat3_lw_hold", rd, 32'hCAFEF00D);

      // Reset in the second wait cycle discards the pending store.
      req_we[1] = 1'b1; req_addr[1] = 32'h40; req_wdata[1] = 32'h12345678;
      req_func3[1] = 3'd2; req_valid[1] = 1'b1;
      chk("clr_pre_ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      chk("clr_in_wait", 32'(req_ready[1] | rsp_valid[1]), 32'd0);
      clr[1] = 1'b1;
      #1;
      chk("clr_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      chk("clr_req_ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
      clr[1] = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (rsp_valid[1]) seen++;
      end
      chk("clr_no_rsp", 32'(seen), 32'd0);
      xact(1, 1'b0, 32'h40, 32'd0, 3'd2, 0, rd, e);
      chk("clr_store_dropped", rd, 32'd0);

      // Back-to-back randomized traffic against the scoreboard.
      b2b(0, 40);
      b2b(1, 25);
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 16; w++) begin
            xact(s, 1'b0, 32'(w*4), 32'd0, 3'd2, 0, rd, e);
         end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the load/store request interface driven by the pipeline's MEM stage.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs RV32I byte/half/word loads (signed/unsigned) and stores selected by func3, then returns a registered response held under backpressure.
- Replaces the zero-latency data memory so the pipeline can be exercised against a stalling memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in the memory array; must be a power of two.
- LATENCY, 0, wait-state cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bytes are used for SB/SH.
- req_func3  input  3  RV32I load/store func3.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response this cycle.
- rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
- rsp_err  output  1  request was misaligned, out of range or had an illegal func3.

Behaviour:
- Reset: asynchronous on clr. State goes to IDLE. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not cleared.
- FSM states are IDLE, WAIT and RESP. req_ready=1 only in IDLE.
- IDLE: when req_valid&req_ready, capture we, addr, wdata and func3. Go to WAIT with counter=LATENCY-1 if LATENCY>0; otherwise go directly to RESP.
- WAIT: decrement the counter each cycle. When the counter is 0, perform the access and go to RESP on the next edge.
- Access timing: the access (read or write) happens on the edge that enters RESP. rsp_rdata and rsp_err are registered on that same edge. rsp_valid therefore rises LATENCY+1 cycles after the accepting edge.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready=1. On the rsp_valid&rsp_ready edge, go to IDLE with rsp_valid=0.
- A new request cannot be accepted on the same edge as the handshake that completes the response. This gives a minimum of 2 cycles per transaction when LATENCY=0.
- Word index = addr[log2(DEPTH)+1:2]. Byte lane = addr[1:0].
- Loads:
  - func3 000 LB: byte at the lane, sign-extended.
  - func3 001 LH: half at addr[1], sign-extended.
  - func3 010 LW: full word.
  - func3 100 LBU and 101 LHU: zero-extended.
- Stores:
  - func3 000 SB: writes only the addressed byte lane.
  - func3 001 SH: writes the addressed half.
  - func3 010 SW: writes the full word.
  - Unselected bytes are untouched. rsp_rdata=0.
- Error conditions (rsp_err=1, rsp_rdata=0, memory not written):
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
  - Load func3 of 011, 110 or 111.
  - Store func3 of 011 or above.
- Request inputs are ignored outside IDLE. They may change freely while the block is in WAIT or RESP.
- clr asserted during WAIT or RESP: the transaction is discarded, any pending store is not performed, and the block returns to the reset values.
- Read-after-write: a load accepted after a store's response has completed returns the stored data.

Test Plan:
- LATENCY=0. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each store response arrives 1 cycle after accept with err=0; the load returns 0xDEADBEEF.
- Extension and lane writes:
  - Stimulus: SW 0x20 data 0x80FF7F01, then LB 0x21, LBU 0x23, LH 0x22, LHU 0x22.
  - Required: LB -> 0x0000007F, LBU -> 0x00000080, LH -> 0xFFFF80FF, LHU -> 0x000080FF.
  - Then SB 0x22 data 0x55, LW 0x20 -> 0x8055_7F01.
- Errors: LW 0x13, SH 0x21, LW at byte address 4*DEPTH, func3=011 load -> rsp_err=1 and rsp_rdata=0 for each; a following LW of the original word returns unchanged data.
- LATENCY=3 with rsp_ready held low for 5 cycles:
  - rsp_valid rises 4 cycles after acceptance.
  - rsp_rdata is stable for the whole hold; req_ready=0 throughout.
  - req_ready returns to 1 on the cycle after the rsp handshake.
- LATENCY=3, SW 0x40 data 0x12345678, then clr pulsed in the 2nd WAIT cycle (old word 0) -> rsp_valid never asserts; after reset, LW 0x40 returns 0.
- Back-to-back traffic with req_valid held high -> accepts occur exactly every LATENCY+2 cycles when rsp_ready=1; no request is lost or duplicated (check against a scoreboard).
